// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and helpers for the PWM frame scheduler
package pwm_pkg;

  localparam int STEPS_DEFAULT = 100;

  typedef logic [6:0] duty_t;

  typedef enum logic [1:0] {
    RUN,
    FETCH,
    CAPTURE
  } fetch_state_e;

  // Prescaler divide ratio so that one frame of `steps` ticks lasts 1/freq seconds.
  function automatic int div_calc(input int clock_freq, input int freq, input int steps);
    return clock_freq / (freq * steps);
  endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// rtl/pwm_frame_timer.sv - prescaler, step counter and duty fetch FSM for one PWM frame
module pwm_frame_timer
  import pwm_pkg::*;
#(
  parameter int DIV   = 500,
  parameter int STEPS = STEPS_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic [6:0] step_o,
  output logic       load_o,
  output logic       capture_o,
  output logic       frame_start_o
);

  localparam int              PW         = $clog2(DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
  localparam duty_t           STEP_LAST  = duty_t'(STEPS - 1);
  localparam duty_t           STEP_PRE   = duty_t'(STEPS - 2);

  // CAPTURE lands two cycles after the fetch tick; it must precede the frame-wrap tick.
  if (DIV < 4) begin : g_div_check
    $error("pwm_frame_timer: DIV must be at least 4");
  end

  logic [PW-1:0] presc_q, presc_d;
  duty_t         step_q, step_d;
  fetch_state_e  state_q;
  logic          load_q, capture_q;
  logic          tick;

  always_comb begin
    tick    = en_i && (presc_q == PRESC_LAST);
    presc_d = presc_q + 1'b1;
    step_d  = step_q;
    if (!en_i || tick) presc_d = '0;
    if (!en_i) begin
      step_d = '0;
    end else if (tick) begin
      step_d = (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
      step_q  <= '0;
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      load_q    <= 1'b0;
      capture_q <= 1'b0;
    end else if (!en_i) begin
      state_q   <= RUN;
      load_q    <= 1'b0;
      capture_q <= 1'b0;
    end else begin
      load_q    <= 1'b0;
      capture_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (tick && (step_q == STEP_PRE)) begin
            state_q <= FETCH;
            load_q  <= 1'b1;
          end
        end
        FETCH: begin
          state_q   <= CAPTURE;
          capture_q <= 1'b1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign step_o        = step_q;
  assign load_o        = load_q;
  assign capture_o     = capture_q;
  assign frame_start_o = tick && (step_q == STEP_LAST);

endmodule

// File: rtl/pwm_frame_scheduler.sv
// rtl/pwm_frame_scheduler.sv - motor and servo PWM frame timing with frame-aligned duty updates
module pwm_frame_scheduler
  import pwm_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int MOTOR_FREQ = 1000,
  parameter int SERVO_FREQ = 50,
  parameter int STEPS      = STEPS_DEFAULT
) (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [6:0] rear_duty_i,
  input  logic [6:0] front_duty_i,
  input  logic [6:0] servo_duty_i,
  output logic       load_rear_o,
  output logic       load_front_o,
  output logic       load_servo_out_o,
  output logic       rear_pwm_o,
  output logic       front_pwm_o,
  output logic       servo_pwm_o,
  output logic       motor_frame_o
);

  localparam int    MOTOR_DIV = div_calc(CLOCK_FREQ, MOTOR_FREQ, STEPS);
  localparam int    SERVO_DIV = div_calc(CLOCK_FREQ, SERVO_FREQ, STEPS);
  localparam duty_t DUTY_MAX  = duty_t'(STEPS);

  function automatic duty_t clamp_duty(input duty_t d);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

  logic [6:0] motor_step, servo_step;
  logic       motor_load, motor_capture, motor_frame_start;
  logic       servo_load, servo_capture, servo_frame_start;

  pwm_frame_timer #(.DIV(MOTOR_DIV), .STEPS(STEPS)) u_motor_timer (
    .clk_i         (clk_i),
    .rst_i         (clr_i),
    .en_i          (en_i),
    .step_o        (motor_step),
    .load_o        (motor_load),
    .capture_o     (motor_capture),
    .frame_start_o (motor_frame_start)
  );

  pwm_frame_timer #(.DIV(SERVO_DIV), .STEPS(STEPS)) u_servo_timer (
    .clk_i         (clk_i),
    .rst_i         (clr_i),
    .en_i          (en_i),
    .step_o        (servo_step),
    .load_o        (servo_load),
    .capture_o     (servo_capture),
    .frame_start_o (servo_frame_start)
  );

  duty_t pend_rear_q, pend_rear_d, pend_front_q, pend_front_d, pend_servo_q, pend_servo_d;
  duty_t act_rear_q, act_rear_d, act_front_q, act_front_d, act_servo_q, act_servo_d;
  logic  motor_frame_q;

  // Pending duties are sampled the cycle after the load strobe and only go live at a frame wrap.
  always_comb begin
    pend_rear_d  = pend_rear_q;
    pend_front_d = pend_front_q;
    pend_servo_d = pend_servo_q;
    act_rear_d   = act_rear_q;
    act_front_d  = act_front_q;
    act_servo_d  = act_servo_q;
    if (motor_capture) begin
      pend_rear_d  = clamp_duty(rear_duty_i);
      pend_front_d = clamp_duty(front_duty_i);
    end
    if (servo_capture) pend_servo_d = clamp_duty(servo_duty_i);
    if (motor_frame_start) begin
      act_rear_d  = pend_rear_q;
      act_front_d = pend_front_q;
    end
    if (servo_frame_start) act_servo_d = pend_servo_q;
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      pend_rear_q   <= '0;
      pend_front_q  <= '0;
      pend_servo_q  <= '0;
      act_rear_q    <= '0;
      act_front_q   <= '0;
      act_servo_q   <= '0;
      motor_frame_q <= 1'b0;
    end else begin
      pend_rear_q   <= pend_rear_d;
      pend_front_q  <= pend_front_d;
      pend_servo_q  <= pend_servo_d;
      act_rear_q    <= act_rear_d;
      act_front_q   <= act_front_d;
      act_servo_q   <= act_servo_d;
      motor_frame_q <= motor_frame_start;
    end
  end

  assign load_rear_o      = motor_load;
  assign load_front_o     = motor_load;
  assign load_servo_out_o = servo_load;
  assign motor_frame_o    = motor_frame_q;
  assign rear_pwm_o       = en_i & (motor_step < act_rear_q);
  assign front_pwm_o      = en_i & (motor_step < act_front_q);
  assign servo_pwm_o      = en_i & (servo_step < act_servo_q);

endmodule
